// File: rtl/drbg_keystream_buffer.sv
// drbg_keystream_buffer
//   Sits downstream of the hash DRBG. Requests 256-bit random words over the
//   DRBG next_bits / next_bits_ready handshake, keeps up to FIFO_DEPTH of them
//   in a small FIFO, and serialises each word into KEY_WIDTH-bit key symbols
//   (least significant slice first) on a valid/ready stream toward the pixel
//   scrambler.
//
// Ports
//   clk                   system clock, rising edge
//   reset                 asynchronous, active-high
//   drbg_init_ready       DRBG is seeded and may be asked for bits
//   drbg_next_bits        registered request level to the DRBG
//   drbg_next_bits_ready  DRBG result flag; a rising edge marks a new word
//   drbg_random_bits      DRBG output word
//   key_data              current key symbol
//   key_valid             key_data is valid
//   key_ready             consumer accepts key_data
//   flush                 synchronous clear of all buffered key material
//   fifo_level            number of DRBG words held in the FIFO
//   underrun              sticky: key_ready seen while key_valid was low
//   words_consumed        count of fully consumed words (wraps)

module drbg_keystream_buffer #(
  parameter int DRBG_WIDTH = 256,
  parameter int KEY_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               drbg_init_ready,
  output logic                               drbg_next_bits,
  input  logic                               drbg_next_bits_ready,
  input  logic [DRBG_WIDTH-1:0]              drbg_random_bits,
  output logic [KEY_WIDTH-1:0]               key_data,
  output logic                               key_valid,
  input  logic                               key_ready,
  input  logic                               flush,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               underrun,
  output logic [31:0]                        words_consumed
);

  localparam int SLICES = DRBG_WIDTH / KEY_WIDTH;
  localparam int IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SLICES - 1);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    GAP
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   ready_q;
  logic                   drbg_edge;
  logic                   discard;
  logic                   discard_next;
  logic                   push;
  logic                   take;
  logic                   pop_word;
  logic [DRBG_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [DRBG_WIDTH-1:0]  head;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [IDX_W-1:0]       idx;

  // A new DRBG word is announced by a rising edge of the ready flag, not its level.
  assign drbg_edge = drbg_next_bits_ready & ~ready_q;

  assign key_valid = (fifo_level != '0);
  assign head      = mem[rd_ptr];
  // Gated so key_data reads zero while the FIFO is empty (including after reset).
  assign key_data  = key_valid ? head[idx*KEY_WIDTH +: KEY_WIDTH] : '0;

  // Flush outranks any consumer handshake in the same cycle.
  assign take     = key_valid & key_ready & ~flush;
  assign pop_word = take & (idx == LAST_IDX);

  // Request FSM: one request outstanding at most, with a one-cycle low gap
  // between consecutive requests so the DRBG sees a clean new request.
  always_comb begin
    state_next   = state;
    discard_next = discard;
    push         = 1'b0;
    case (state)
      IDLE: begin
        if (drbg_init_ready && (fifo_level < DEPTH_LVL)) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (!drbg_init_ready) begin
          // Abandoned request: nothing is in flight any more, so nothing to discard.
          state_next   = IDLE;
          discard_next = 1'b0;
        end else if (flush) begin
          // The word in flight belongs to flushed key material; drop it on arrival.
          // A DRBG edge landing in this same cycle is ignored.
          discard_next = 1'b1;
        end else if (drbg_edge) begin
          state_next = GAP;
          if (discard) begin
            discard_next = 1'b0;
          end else begin
            push = 1'b1;
          end
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ready_q        <= 1'b0;
      discard        <= 1'b0;
      drbg_next_bits <= 1'b0;
    end else begin
      state          <= state_next;
      ready_q        <= drbg_next_bits_ready;
      discard        <= discard_next;
      drbg_next_bits <= (state_next == REQ);
    end
  end

  // Storage needs no reset: key_data is gated by key_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= drbg_random_bits;
    end
  end

  // FIFO pointers and occupancy. Pointers wrap naturally as the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_word) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop_word})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Serialiser slice index, underrun flag and consumed-word counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx            <= '0;
      underrun       <= 1'b0;
      words_consumed <= '0;
    end else begin
      if (flush) begin
        idx      <= '0;
        underrun <= 1'b0;
      end else begin
        if (take) begin
          idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
        if (key_ready && !key_valid) begin
          underrun <= 1'b1;
        end
      end
      if (pop_word) begin
        words_consumed <= words_consumed + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_drbg_keystream_buffer.sv
// tb_drbg_keystream_buffer
//   Scoreboard bench for drbg_keystream_buffer. A behavioural DRBG answers each
//   request a few cycles later; every word it hands over is split into bytes and
//   queued as the expected key stream, and a monitor pops and compares whenever
//   the DUT completes a key handshake.

`timescale 1ns/1ps

module tb_drbg_keystream_buffer;

  localparam int DW     = 256;
  localparam int KW     = 8;
  localparam int DEPTH  = 4;
  localparam int SLICES = DW / KW;

  logic           clk = 1'b0;
  logic           reset;
  logic           drbg_init_ready;
  logic           drbg_next_bits;
  logic           drbg_next_bits_ready;
  logic [DW-1:0]  drbg_random_bits;
  logic [KW-1:0]  key_data;
  logic           key_valid;
  logic           key_ready;
  logic           flush;
  logic [2:0]     fifo_level;
  logic           underrun;
  logic [31:0]    words_consumed;

  // Behavioural DRBG state
  logic           model_ready;
  logic           spur;
  bit             use_fixed;
  bit             drop_next;
  logic [DW-1:0]  fixed_word;
  int             drbg_cnt;
  int             delivered;

  // Scoreboard state
  logic [KW-1:0]  exp_q[$];
  int             byte_cnt;
  int             exp_words;
  bit             wc_pending;
  bit             prev_hold;
  logic [KW-1:0]  prev_data;
  int             full_req_violations;

  int             vectors;
  int             miscompares;

  always #5 clk = ~clk;

  assign drbg_next_bits_ready = model_ready | spur;

  drbg_keystream_buffer #(
    .DRBG_WIDTH (DW),
    .KEY_WIDTH  (KW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .drbg_init_ready      (drbg_init_ready),
    .drbg_next_bits       (drbg_next_bits),
    .drbg_next_bits_ready (drbg_next_bits_ready),
    .drbg_random_bits     (drbg_random_bits),
    .key_data             (key_data),
    .key_valid            (key_valid),
    .key_ready            (key_ready),
    .flush                (flush),
    .fifo_level           (fifo_level),
    .underrun             (underrun),
    .words_consumed       (words_consumed)
  );

  task automatic checkOutput(input string name, input longint unsigned actual,
                             input longint unsigned expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One stimulus cycle: drive inputs just after the rising edge.
  task automatic applyStimulus(input bit init, input bit rdy);
    @(posedge clk);
    #1;
    drbg_init_ready = init;
    key_ready       = rdy;
  endtask

  task automatic doFlush();
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    byte_cnt  = 0;
    prev_hold = 1'b0;
  endtask

  function automatic logic [DW-1:0] randWord();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  // Behavioural DRBG: once a request has been seen for three cycles it presents
  // a word and holds its ready flag high until the request is withdrawn.
  always @(posedge clk) begin
    logic [DW-1:0] w;
    #2;
    if (reset || !drbg_next_bits) begin
      drbg_cnt    = 0;
      model_ready = 1'b0;
    end else if (!model_ready) begin
      drbg_cnt++;
      if (drbg_cnt >= 3) begin
        w                = use_fixed ? fixed_word : randWord();
        drbg_random_bits = w;
        model_ready      = 1'b1;
        delivered++;
        if (drop_next) begin
          drop_next = 1'b0;
        end else begin
          for (int i = 0; i < SLICES; i++) exp_q.push_back(w[i*KW +: KW]);
        end
      end
    end
  end

  // Monitor: compares every completed key handshake against the scoreboard.
  always @(negedge clk) begin
    logic [KW-1:0] e;
    if (!reset) begin
      if (wc_pending) begin
        checkOutput("words_consumed", words_consumed, exp_words);
        wc_pending = 1'b0;
      end
      if (prev_hold && key_valid) checkOutput("key_hold", key_data, prev_data);
      if (drbg_next_bits && fifo_level == 3'(DEPTH)) full_req_violations++;
      if (key_valid && key_ready && !flush) begin
        if (exp_q.size() == 0) begin
          checkOutput("key_unexpected", {1'b1, key_data}, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("key_data", key_data, e);
          byte_cnt++;
          if (byte_cnt == SLICES) begin
            byte_cnt   = 0;
            exp_words++;
            wc_pending = 1'b1;
          end
        end
      end
      prev_hold = key_valid && !key_ready && !flush;
      prev_data = key_data;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  cnt;
    bit  seen;
    bit  init;

    reset           = 1'b1;
    drbg_init_ready = 1'b0;
    key_ready       = 1'b0;
    flush           = 1'b0;
    spur            = 1'b0;
    model_ready     = 1'b0;
    drbg_random_bits = '0;
    use_fixed       = 1'b1;
    drop_next       = 1'b0;
    drbg_cnt        = 0;
    delivered       = 0;
    byte_cnt        = 0;
    exp_words       = 0;
    wc_pending      = 1'b0;
    prev_hold       = 1'b0;
    prev_data       = '0;
    full_req_violations = 0;
    vectors         = 0;
    miscompares     = 0;
    for (int i = 0; i < SLICES; i++) fixed_word[i*KW +: KW] = KW'(i);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_next_bits", drbg_next_bits, 0);
    checkOutput("rst_key_valid", key_valid, 0);
    checkOutput("rst_key_data", key_data, 0);
    checkOutput("rst_fifo_level", fifo_level, 0);
    checkOutput("rst_underrun", underrun, 0);
    checkOutput("rst_words", words_consumed, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill the FIFO with no consumer; requests must stop at full.
    $display("[TB] fill FIFO");
    applyStimulus(1'b1, 1'b0);
    cnt = 0;
    while (fifo_level != 3'(DEPTH) && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("fill_level", fifo_level, DEPTH);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen |= drbg_next_bits;
    end
    checkOutput("no_req_when_full", seen, 0);
    checkOutput("fill_delivered", delivered, DEPTH);
    checkOutput("fill_first_key", key_data, 8'h00);

    // Continuous consumer: 32 back-to-back symbols then one word consumed.
    $display("[TB] continuous drain");
    applyStimulus(1'b1, 1'b1);
    cnt = 0;
    repeat (SLICES) begin
      @(negedge clk);
      if (!key_valid) cnt++;
    end
    @(negedge clk);
    checkOutput("stream_gaps", cnt, 0);
    checkOutput("first_word_consumed", words_consumed, 1);
    repeat (60) applyStimulus(1'b1, 1'b1);

    // Alternating consumer: data must hold during ready=0.
    $display("[TB] toggled ready");
    for (int i = 0; i < 200; i++) applyStimulus(1'b1, i[0]);

    // Random traffic with random words; init_ready only moves outside a request.
    $display("[TB] random traffic");
    use_fixed = 1'b0;
    init      = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if (!drbg_next_bits && $urandom_range(0, 9) == 0) init = ~init;
      applyStimulus(init, 1'($urandom_range(0, 1)));
    end

    // Stop requesting and drain.
    cnt = 0;
    do begin
      applyStimulus(1'b1, 1'b1);
      cnt++;
    end while (drbg_next_bits && cnt < 50);
    drbg_init_ready = 1'b0;
    cnt = 0;
    while ((exp_q.size() != 0 || key_valid) && cnt < 600) begin
      @(negedge clk);
      cnt++;
    end
    repeat (3) @(negedge clk);
    checkOutput("drain_queue_empty", exp_q.size(), 0);
    checkOutput("drain_key_valid", key_valid, 0);
    checkOutput("drain_level", fifo_level, 0);
    checkOutput("drain_words", words_consumed, exp_words);

    // Underrun: ready with nothing to give is sticky until flush.
    $display("[TB] underrun");
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("underrun_set", underrun, 1);
    checkOutput("underrun_valid", key_valid, 0);
    repeat (3) applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("underrun_sticky", underrun, 1);
    doFlush();
    @(negedge clk);
    checkOutput("underrun_cleared", underrun, 0);

    // Flush during a request: the in-flight word is discarded.
    $display("[TB] flush during request");
    use_fixed  = 1'b1;
    fixed_word = {SLICES{8'hAA}};
    drop_next  = 1'b1;
    applyStimulus(1'b1, 1'b0);
    cnt = 0;
    while (!drbg_next_bits && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput("flush_req_seen", drbg_next_bits, 1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    cnt = 0;
    while (!model_ready && cnt < 20) begin
      @(posedge clk);
      #3;
      cnt++;
    end
    fixed_word = {SLICES{8'h55}};
    checkOutput("flush_dropped_flag", drop_next, 0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (fifo_level != 0) seen = 1'b1;
    end
    checkOutput("flush_level_zero", seen, 0);
    cnt = 0;
    while (!key_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("after_flush_key", key_data, 8'h55);
    cnt = 0;
    do begin
      applyStimulus(1'b1, 1'b0);
      cnt++;
    end while (drbg_next_bits && cnt < 50);
    drbg_init_ready = 1'b0;
    key_ready       = 1'b1;
    cnt = 0;
    while ((exp_q.size() != 0 || key_valid) && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    repeat (3) @(negedge clk);
    checkOutput("flush_drain_empty", exp_q.size(), 0);
    key_ready = 1'b0;

    // init_ready drops mid-request: request withdrawn, later ready edge ignored.
    $display("[TB] init_ready drop");
    cnt = delivered;
    applyStimulus(1'b1, 1'b0);
    while (!drbg_next_bits && delivered == cnt) begin
      @(posedge clk);
      #1;
    end
    drbg_init_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("drop_next_bits", drbg_next_bits, 0);
    @(posedge clk);
    #1;
    spur = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    spur = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("drop_level", fifo_level, 0);
    checkOutput("drop_valid", key_valid, 0);
    checkOutput("drop_no_delivery", delivered, cnt);

    // Reset during a request returns everything to the reset state at once.
    $display("[TB] reset mid-request");
    applyStimulus(1'b1, 1'b0);
    cnt = 0;
    while (!drbg_next_bits && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midreset_next_bits", drbg_next_bits, 0);
    checkOutput("midreset_level", fifo_level, 0);
    checkOutput("midreset_words", words_consumed, 0);
    exp_q.delete();
    byte_cnt   = 0;
    exp_words  = 0;
    wc_pending = 1'b0;
    prev_hold  = 1'b0;

    checkOutput("req_while_full", full_req_violations, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
